// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM states, opcodes and
// the position of the opcode field inside an instruction word.
package prog_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_IMM,
        ST_WAIT,
        ST_FINISH
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

endpackage

// File: rtl/prog_sequencer_ram.sv
// Program store: synchronous write from the loader, asynchronous read so the
// addressed word reaches the processor in the same cycle the FSM selects it.
module prog_ram #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 9
) (
    input  logic              Clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Instruction source for the 9-bit multicycle processor: issues each word with
// a one-cycle Run, feeds the mvi immediate, and waits for Done with a watchdog.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int WORD_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Halt,
    input  logic [ADDR_W-1:0] ProgLen,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [WORD_W-1:0] LdData,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        InstrCnt,
    output logic              Busy,
    output logic              Finished,
    output logic              Err
);

    localparam int WDOG_W = 4;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [7:0]          r_cnt;
    logic                r_err;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_is_mvi;

    logic [ADDR_W-1:0]   w_rd_addr;
    logic [WORD_W-1:0]   w_rd_data;
    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W:0]     w_pc_sum;
    logic [ADDR_W-1:0]   w_pc_next;
    logic                w_we;
    logic                w_cur_mvi;
    logic                w_complete;
    logic                w_begin;
    logic                w_clr_err;
    logic                w_timeout;

    // Loader writes are only honoured while no program is executing.
    assign w_we      = LdEn & ((r_state == ST_IDLE) | (r_state == ST_FINISH));
    assign w_rd_addr = (r_state == ST_IMM) ? r_pc + ADDR_W'(1) : r_pc;

    prog_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .Clock   (Clock),
        .i_we    (w_we),
        .i_waddr (LdAddr),
        .i_wdata (LdData),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign w_cur_mvi = (w_rd_data[OPC_MSB:OPC_LSB] == OP_MVI);
    assign w_step    = r_is_mvi ? ADDR_W'(2) : ADDR_W'(1);
    // End-of-program test uses one extra bit so a wrapped PC never looks "short".
    assign w_pc_sum  = {1'b0, r_pc} + {1'b0, w_step};
    assign w_pc_next = w_pc_sum[ADDR_W-1:0];

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_begin    = 1'b0;
        w_clr_err  = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_clr_err = 1'b1;
                    if (ProgLen != '0) begin
                        w_begin = 1'b1;
                        w_next  = ST_ISSUE;
                    end else begin
                        w_next  = ST_FINISH;
                    end
                end
            end
            ST_ISSUE:  w_next = w_cur_mvi ? ST_IMM : ST_WAIT;
            ST_IMM: begin
                if (Done) w_complete = 1'b1;
                else      w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                if (Done) begin
                    w_complete = 1'b1;
                end else if (r_wdog == WDOG_W'(TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_FINISH;
                end
            end
            ST_FINISH: if (!Start) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_complete)
            w_next = (Halt || (w_pc_sum >= {1'b0, ProgLen})) ? ST_FINISH : ST_ISSUE;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_pc     <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
            r_is_mvi <= 1'b0;
        end else begin
            if (w_begin) begin
                r_pc  <= '0;
                r_cnt <= '0;
            end
            if (w_clr_err)      r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
            if (r_state == ST_ISSUE) begin
                r_wdog   <= '0;
                r_is_mvi <= w_cur_mvi;
            end else if (r_state == ST_WAIT) begin
                r_wdog   <= r_wdog + WDOG_W'(1);
            end
            if (w_complete) begin
                r_pc <= w_pc_next;
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        DIN = '0;
        if ((r_state == ST_ISSUE) || (r_state == ST_IMM))
            DIN = w_rd_data;
    end

    assign Run      = (r_state == ST_ISSUE);
    assign Busy     = (r_state == ST_ISSUE) | (r_state == ST_IMM) | (r_state == ST_WAIT);
    assign Finished = (r_state == ST_FINISH);
    assign PC       = r_pc;
    assign InstrCnt = r_cnt;
    assign Err      = r_err;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a small processor model supplies Done, and a
// program-level model predicts the output trace cycle by cycle.
module tb_prog_sequencer;

    localparam logic [2:0] T_MV = 3'd0, T_MVI = 3'd1, T_ADD = 3'd2, T_SUB = 3'd3;

    logic       Clock = 1'b0, Resetn = 1'b1, Start = 1'b0, Halt = 1'b0, LdEn = 1'b0;
    logic [4:0] ProgLen = '0, LdAddr = '0, PC;
    logic [8:0] LdData = '0, DIN;
    logic       Done, Run, Busy, Finished, Err;
    logic [7:0] InstrCnt;

    int n_checks = 0, n_fail = 0;

    always #5 Clock = ~Clock;

    prog_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Halt(Halt), .ProgLen(ProgLen),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .InstrCnt(InstrCnt), .Busy(Busy),
        .Finished(Finished), .Err(Err)
    );

    // Processor model: mv/mvi finish in T1, add/sub in T3.
    logic [8:0] preg [8];
    logic [8:0] pir = '0;
    int         tstep = 0;
    bit         hang_add = 1'b0;
    wire [2:0]  p_op = pir[8:6];

    assign Done = ((tstep == 1) && ((p_op == T_MV) || (p_op == T_MVI))) ||
                  ((tstep == 3) && ((p_op == T_ADD) || (p_op == T_SUB)) && !hang_add);

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep <= 0;
        end else if (Run) begin
            pir   <= DIN;
            tstep <= 1;
        end else if (tstep != 0) begin
            if (Done) begin
                tstep <= 0;
                case (p_op)
                    T_MV:  preg[pir[5:3]] <= preg[pir[2:0]];
                    T_MVI: preg[pir[5:3]] <= DIN;
                    T_ADD: preg[pir[5:3]] <= preg[pir[5:3]] + preg[pir[2:0]];
                    T_SUB: preg[pir[5:3]] <= preg[pir[5:3]] - preg[pir[2:0]];
                    default: ;
                endcase
            end else if (tstep < 1000) begin
                tstep <= tstep + 1;
            end
        end
    end

    typedef struct packed {
        logic [8:0] din; logic run; logic [4:0] pc; logic [7:0] cnt;
        logic busy; logic fin; logic err;
    } exp_t;

    exp_t       expq[$];
    exp_t       ce;
    logic [8:0] mmem [32];
    int         m_pc = 0, m_cnt = 0;
    bit         m_err = 1'b0;
    bit         armed = 1'b0;
    int         run_seen = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [8:0] din, input logic run, input logic busy, input logic fin);
        exp_t e;
        e.din = din; e.run = run; e.pc = 5'(m_pc); e.cnt = 8'(m_cnt);
        e.busy = busy; e.fin = fin; e.err = m_err;
        expq.push_back(e);
    endtask

    // Expected trace: ISSUE, then IMM for mvi, then WAIT cycles per opcode latency.
    task automatic build(input int plen, input int halt_idx, input bit hang);
        logic [8:0] w;
        logic [2:0] op;
        int i = 0, nxt;
        bit fin = 1'b0;
        m_err = 1'b0;
        if (plen == 0) fin = 1'b1;
        else begin m_pc = 0; m_cnt = 0; end
        while (!fin) begin
            w  = mmem[m_pc];
            op = w[8:6];
            push(w, 1'b1, 1'b1, 1'b0);
            if (op == T_MVI) push(mmem[(m_pc + 1) % 32], 1'b0, 1'b1, 1'b0);
            if (hang && ((op == T_ADD) || (op == T_SUB))) begin
                repeat (16) push('0, 1'b0, 1'b1, 1'b0);
                m_err = 1'b1;
                fin   = 1'b1;
            end else begin
                if ((op == T_ADD) || (op == T_SUB)) repeat (3) push('0, 1'b0, 1'b1, 1'b0);
                else if (op == T_MV)                push('0, 1'b0, 1'b1, 1'b0);
                nxt  = m_pc + ((op == T_MVI) ? 2 : 1);
                m_pc = nxt % 32;
                if (m_cnt < 255) m_cnt++;
                if ((i == halt_idx) || (nxt >= plen)) fin = 1'b1;
                i++;
            end
        end
        push('0, 1'b0, 1'b0, 1'b1);
        push('0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge Clock) begin
        if (Run === 1'b1) run_seen++;
        if (armed && (expq.size() > 0)) begin
            ce = expq.pop_front();
            chk($sformatf("trace_cycle%0d", cyc),
                32'({DIN, Run, PC, InstrCnt, Busy, Finished, Err}), 32'(ce));
            cyc++;
        end
    end

    task automatic load(input int a, input logic [8:0] d);
        LdEn = 1'b1; LdAddr = 5'(a); LdData = d;
        @(posedge Clock); #1;
        LdEn = 1'b0;
        mmem[a] = d;
    endtask

    task automatic go(input int plen, input int halt_idx, input bit hang);
        build(plen, halt_idx, hang);
        ProgLen = 5'(plen);
        Start   = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        armed = 1'b1;
    endtask

    task automatic wait_q();
        int k = 0;
        while ((expq.size() > 0) && (k < 200)) begin @(posedge Clock); k++; end
        #1;
        chk("trace_drained", 32'(expq.size()), 32'd0);
        expq.delete();
        armed = 1'b0;
    endtask

    task automatic wait_runs(input int target);
        int k = 0;
        while ((run_seen < target) && (k < 60)) begin @(posedge Clock); k++; end
        chk("run_wait", 32'(run_seen >= target), 32'd1);
    endtask

    initial begin
        int base;
        #3 Resetn = 1'b0;
        #4;
        chk("rst_din", 32'(DIN), 0);       chk("rst_run", 32'(Run), 0);
        chk("rst_pc", 32'(PC), 0);         chk("rst_cnt", 32'(InstrCnt), 0);
        chk("rst_busy", 32'(Busy), 0);     chk("rst_fin", 32'(Finished), 0);
        chk("rst_err", 32'(Err), 0);
        @(posedge Clock); #1 Resetn = 1'b1;
        @(posedge Clock); #1;

        // mvi R0,5 ; mv R1,R0
        load(0, 9'b001_000_000); load(1, 9'd5); load(2, 9'b000_001_000);
        base = run_seen;
        go(3, -1, 0); wait_q();
        chk("A_runs", 32'(run_seen - base), 2);
        chk("A_R0", 32'(preg[0]), 5);      chk("A_R1", 32'(preg[1]), 5);
        chk("A_cnt", 32'(InstrCnt), 2);    chk("A_pc", 32'(PC), 3);

        // Loader writes to PC+1 while busy must be dropped.
        go(3, -1, 0);
        LdEn = 1'b1; LdAddr = 5'd1; LdData = 9'h1FF;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        LdEn = 1'b0;
        wait_q();
        go(3, -1, 0); wait_q();
        chk("ldbusy_R0", 32'(preg[0]), 5);

        // mvi R0,5 ; mvi R1,3 ; add R0,R1 ; sub R0,R1 ; mv R2,R0 ; mv R3,R1
        load(0, 9'b001_000_000); load(1, 9'd5); load(2, 9'b001_001_000); load(3, 9'd3);
        load(4, 9'b010_000_001); load(5, 9'b011_000_001);
        load(6, 9'b000_010_000); load(7, 9'b000_011_001);
        go(5, -1, 0); wait_q();
        chk("B_R0", 32'(preg[0]), 8);      chk("B_pc", 32'(PC), 5);
        chk("B_cnt", 32'(InstrCnt), 3);

        go(8, -1, 0); wait_q();
        chk("C_R0", 32'(preg[0]), 5);      chk("C_R2", 32'(preg[2]), 5);
        chk("C_R3", 32'(preg[3]), 3);      chk("C_pc", 32'(PC), 8);
        chk("C_cnt", 32'(InstrCnt), 6);

        // Halt raised during the add's WAIT.
        base = run_seen;
        go(8, 2, 0);
        wait_runs(base + 3);
        #1 Halt = 1'b1;
        wait_q();
        Halt = 1'b0;
        chk("halt_pc", 32'(PC), 5);        chk("halt_cnt", 32'(InstrCnt), 3);
        chk("halt_R0", 32'(preg[0]), 8);
        repeat (3) @(posedge Clock); #1;
        chk("halt_no_more_run", 32'(run_seen - base), 3);

        // Processor never answers the add.
        hang_add = 1'b1;
        go(5, -1, 1); wait_q();
        hang_add = 1'b0;
        chk("to_err", 32'(Err), 1);        chk("to_pc", 32'(PC), 4);
        chk("to_cnt", 32'(InstrCnt), 2);
        go(5, -1, 0); wait_q();
        chk("to_err_cleared", 32'(Err), 0);

        // mvi in the last slot, then an empty program.
        go(1, -1, 0); wait_q();
        chk("last_mvi_pc", 32'(PC), 2);    chk("last_mvi_cnt", 32'(InstrCnt), 1);
        go(0, -1, 0); wait_q();
        chk("empty_pc", 32'(PC), 2);       chk("empty_cnt", 32'(InstrCnt), 1);

        // Reset in the middle of the add's WAIT.
        base = run_seen;
        go(5, -1, 0);
        wait_runs(base + 3);
        @(posedge Clock); #1;
        armed = 1'b0;
        expq.delete();
        Resetn = 1'b0;
        #1;
        chk("midrst_busy", 32'(Busy), 0);  chk("midrst_run", 32'(Run), 0);
        chk("midrst_din", 32'(DIN), 0);
        #2 Resetn = 1'b1;
        m_pc = 0; m_cnt = 0; m_err = 1'b0;
        #1;
        chk("midrst_pc", 32'(PC), 0);      chk("midrst_cnt", 32'(InstrCnt), 0);
        @(posedge Clock); #1;

        // Load and Start in the same IDLE cycle: mv R4,R1 runs from the new word.
        mmem[0] = 9'b000_100_001;
        LdEn = 1'b1; LdAddr = 5'd0; LdData = 9'b000_100_001;
        go(1, -1, 0);
        LdEn = 1'b0;
        wait_q();
        chk("ldstart_R4", 32'(preg[4]), 3);
        chk("ldstart_pc", 32'(PC), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
